// File: rtl/board_mine_placer.sv
// Wishbone classic master that clears the Minesweeper board and then places MINES mines
// at LFSR-chosen cells using read-check-write. Optional watchdog: BOARD_PLACER_TIMEOUT_EN.
module board_mine_placer #(
    parameter int          BOARD_SIZE = 16,
    parameter int          ADDR_W     = 8,
    parameter int          MINES      = 40,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic              clk74MHz,
    input  logic              rst_n,
    input  logic              start,
    input  logic [15:0]       seed,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] mines_placed,
    output logic              wb_cyc_o,
    output logic              wb_stb_o,
    output logic              wb_we_o,
    output logic [ADDR_W-1:0] wb_adr_o,
    output logic [7:0]        wb_dat_o,
    input  logic [7:0]        wb_dat_i,
    input  logic              wb_ack_i,
    output logic [2:0]        dbg_state_o
);
    localparam int                CELLS    = BOARD_SIZE * BOARD_SIZE;
    localparam logic [ADDR_W-1:0] LAST_ADR = ADDR_W'(CELLS - 1);
    localparam logic [ADDR_W-1:0] MINES_N  = ADDR_W'(MINES);
    localparam logic [ADDR_W:0]   CELLS_W  = (ADDR_W + 1)'(CELLS);

    if (MINES < 1 || MINES > CELLS - 1) begin : g_bad_mines
        $error("board_mine_placer: MINES must be in 1 .. BOARD_SIZE*BOARD_SIZE-1");
    end
    if ((2 ** ADDR_W) < CELLS || ADDR_W > 16) begin : g_bad_addr
        $error("board_mine_placer: ADDR_W cannot address every cell");
    end

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_PICK, S_READ, S_CHECK, S_WRITE, S_FINISH
    } state_t;

    state_t            state_q, state_d;
    logic [15:0]       lfsr_q, lfsr_d, lfsr_step;
    logic [ADDR_W-1:0] adr_q, adr_d, cnt_q, cnt_d, cand;
    logic [7:0]        dat_q, dat_d;
    logic              cyc_q, cyc_d, we_q, we_d, busy_q, busy_d, done_q, done_d;
    logic              mine_q, mine_d, ack;
    logic              unused_dat;

    assign lfsr_step  = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    assign cand       = lfsr_step[ADDR_W-1:0];
    assign ack        = cyc_q && wb_ack_i;
    assign unused_dat = ^wb_dat_i[7:1];

`ifdef BOARD_PLACER_TIMEOUT_EN
    logic [7:0] wdog_q, wdog_d;
    logic       err_q, err_d;
`endif

    // Each access is presented with cyc high, dropped the cycle after ack, and the
    // following cyc-low cycle is where the state decides what comes next.
    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        cyc_d   = cyc_q;
        we_d    = we_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        cnt_d   = cnt_q;
        mine_d  = mine_q;
`ifdef BOARD_PLACER_TIMEOUT_EN
        wdog_d  = 8'd0;
        err_d   = err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    lfsr_d  = (seed == 16'd0) ? LFSR_SEED : seed;
                    adr_d   = '0;
                    dat_d   = 8'h00;
                    we_d    = 1'b1;
                    cyc_d   = 1'b1;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
`ifdef BOARD_PLACER_TIMEOUT_EN
                    err_d   = 1'b0;
`endif
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                if (cyc_q) begin
                    if (ack) begin
                        cyc_d = 1'b0;
                        if (adr_q == LAST_ADR) state_d = S_PICK;
                        else                   adr_d   = adr_q + 1'b1;
                    end
                end else begin
                    cyc_d = 1'b1;
                end
            end
            S_PICK: begin
                lfsr_d = lfsr_step;
                if ({1'b0, cand} < CELLS_W) begin
                    adr_d   = cand;
                    we_d    = 1'b0;
                    dat_d   = 8'h00;
                    cyc_d   = 1'b1;
                    state_d = S_READ;
                end
            end
            S_READ: begin
                if (cyc_q) begin
                    if (ack) begin
                        cyc_d  = 1'b0;
                        mine_d = wb_dat_i[0];
                    end
                end else begin
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (mine_q) begin
                    state_d = S_PICK;
                end else begin
                    we_d    = 1'b1;
                    dat_d   = 8'h01;
                    cyc_d   = 1'b1;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                if (cyc_q) begin
                    if (ack) begin
                        cyc_d = 1'b0;
                        cnt_d = cnt_q + 1'b1;
                    end
                end else if (cnt_q == MINES_N) begin
                    state_d = S_FINISH;
                end else begin
                    state_d = S_PICK;
                end
            end
            S_FINISH: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                we_d    = 1'b0;
                dat_d   = 8'h00;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
`ifdef BOARD_PLACER_TIMEOUT_EN
        // A stalled slave aborts the whole run; the board is left as it is.
        if (cyc_q && !wb_ack_i) begin
            wdog_d = wdog_q + 8'd1;
            if (wdog_d == 8'hFF) begin
                cyc_d   = 1'b0;
                we_d    = 1'b0;
                err_d   = 1'b1;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        end
`endif
    end

    always_ff @(posedge clk74MHz or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            lfsr_q  <= LFSR_SEED;
            adr_q   <= '0;
            dat_q   <= 8'h00;
            cyc_q   <= 1'b0;
            we_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
            mine_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            cyc_q   <= cyc_d;
            we_q    <= we_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
            mine_q  <= mine_d;
        end
    end

`ifdef BOARD_PLACER_TIMEOUT_EN
    always_ff @(posedge clk74MHz or negedge rst_n) begin
        if (!rst_n) begin
            wdog_q <= 8'd0;
            err_q  <= 1'b0;
        end else begin
            wdog_q <= wdog_d;
            err_q  <= err_d;
        end
    end
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign busy         = busy_q;
    assign done         = done_q;
    assign mines_placed = cnt_q;
    assign wb_cyc_o     = cyc_q;
    assign wb_stb_o     = cyc_q;
    assign wb_we_o      = we_q;
    assign wb_adr_o     = adr_q;
    assign wb_dat_o     = dat_q;
    assign dbg_state_o  = state_q;
endmodule

// File: tb/tb_board_mine_placer.sv
// Bench for board_mine_placer: a Wishbone slave memory model, a scoreboard fed by a
// board-level reference model, and a monitor that checks every acked bus access.
module tb_board_mine_placer;
    localparam int CELLS = 256;
    localparam int MINES = 40;
    localparam int W     = 17;

    logic        clk74MHz = 1'b0;
    logic        rst_n    = 1'b0;
    logic        start    = 1'b0;
    logic [15:0] seed     = 16'h0000;
    logic        busy, done, err;
    logic [7:0]  mines_placed;
    logic        wb_cyc_o, wb_stb_o, wb_we_o;
    logic [7:0]  wb_adr_o, wb_dat_o;
    logic [7:0]  wb_dat_i;
    logic        wb_ack_i;
    logic [2:0]  dbg_state_o;

    board_mine_placer #(
        .BOARD_SIZE(16), .ADDR_W(8), .MINES(MINES), .LFSR_SEED(16'hACE1)
    ) dut (
        .clk74MHz(clk74MHz), .rst_n(rst_n), .start(start), .seed(seed),
        .busy(busy), .done(done), .err(err), .mines_placed(mines_placed),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
        .wb_ack_i(wb_ack_i), .dbg_state_o(dbg_state_o)
    );

    initial forever #5 clk74MHz = ~clk74MHz;

    int         checks = 0;
    int         errors = 0;
    logic [W-1:0] exp_q[$];
    logic [7:0] mem[CELLS];
    bit         exp_board[CELLS];
    bit         snap_board[CELLS];
    bit         mon_en  = 1'b0;
    bit         spur_en = 1'b1;
    bit         no_ack  = 1'b0;
    int         wait_k  = 1;
    int         preset_n = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk74MHz);
        #1;
    endtask

    // Reference: full clear, then LFSR candidates read until MINES free cells are written.
    task automatic build_expect(input logic [15:0] s, input int pre);
        logic [15:0] l;
        int placed;
        int cand;
        for (int a = 0; a < CELLS; a++) begin
            exp_q.push_back({1'b1, 8'(a), 8'h00});
            exp_board[a] = (a < pre);
        end
        l = (s == 16'd0) ? 16'hACE1 : s;
        placed = 0;
        while (placed < MINES) begin
            l = l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
            cand = int'(l[7:0]);
            if (cand >= CELLS) continue;
            exp_q.push_back({1'b0, 8'(cand), 8'h00});
            if (exp_board[cand]) continue;
            exp_board[cand] = 1'b1;
            placed++;
            exp_q.push_back({1'b1, 8'(cand), 8'h01});
        end
    endtask

    // Slave: acks wait_k cycles after stb rises; random acks while stb is low.
    int wcnt = 0;
    initial begin
        wb_ack_i = 1'b0;
        wb_dat_i = 8'h00;
        forever begin
            tick();
            if (wb_cyc_o && wb_stb_o) begin
                if (!no_ack && wcnt >= wait_k) begin
                    wb_ack_i = 1'b1;
                    if (wb_we_o) begin
                        mem[wb_adr_o] = (wb_dat_o == 8'h00 && int'(wb_adr_o) < preset_n) ? 8'h01 : wb_dat_o;
                        wb_dat_i = 8'($urandom);
                    end else begin
                        wb_dat_i = mem[wb_adr_o];
                    end
                    wcnt = 0;
                end else begin
                    wb_ack_i = 1'b0;
                    wcnt++;
                end
            end else begin
                wb_ack_i = spur_en ? 1'($urandom_range(0, 1)) : 1'b0;
                wb_dat_i = 8'($urandom);
                wcnt = 0;
            end
        end
    end

    // Monitor: pops the scoreboard on every acked access and checks bus discipline.
    logic         prev_ack = 1'b0;
    logic         prev_stb = 1'b0;
    logic [W-1:0] prev_bus = '0;
    logic [W-1:0] mon_e;
    always @(negedge clk74MHz) begin
        if (mon_en) begin
            check("cyc_eq_stb", wb_cyc_o, wb_stb_o);
            if (prev_ack) check("idle_after_ack", wb_cyc_o, 1'b0);
            if (prev_stb && !prev_ack && wb_stb_o)
                check("hold_stable", {wb_we_o, wb_adr_o, wb_dat_o}, prev_bus);
            if (wb_cyc_o && wb_stb_o && wb_ack_i) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_access", {wb_we_o, wb_adr_o, wb_dat_o}, 32'hFFFF_FFFF);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("bus_we_adr", {wb_we_o, wb_adr_o}, mon_e[16:8]);
                    if (mon_e[16]) check("bus_wdat", wb_dat_o, mon_e[7:0]);
                end
            end
        end
        prev_ack = wb_cyc_o && wb_stb_o && wb_ack_i;
        prev_stb = wb_stb_o;
        prev_bus = {wb_we_o, wb_adr_o, wb_dat_o};
    end

    task automatic run_game(input logic [15:0] s, input int pre, input int k, input bit busy_start);
        int c, first_rd, mism;
        bit seen_done, pb;
        preset_n = pre;
        wait_k   = k;
        build_expect(s, pre);
        start = 1'b1;
        seed  = s;
        tick();
        start = 1'b0;
        check("busy_after_start", busy, 1'b1);
        check("first_access", {wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o}, {3'b111, 8'h00, 8'h00});
        c = 0;
        first_rd = -1;
        seen_done = 1'b0;
        pb = 1'b1;
        while (!seen_done && c < 12000) begin
            if (first_rd < 0 && wb_cyc_o && !wb_we_o) first_rd = c;
            if (busy_start && c == 100) begin
                start = 1'b1;
                seed  = s ^ 16'h5A5A;
            end else begin
                start = 1'b0;
            end
            pb = busy;
            tick();
            c++;
            if (done) seen_done = 1'b1;
        end
        start = 1'b0;
        check("done_seen", seen_done, 1'b1);
        if (k == 1) check("clear_cycles", first_rd, 768);
        check("busy_fell_with_done", {pb, busy}, 2'b10);
        check("mines_placed", mines_placed, MINES);
        check("err_low", err, 1'b0);
        tick();
        check("done_one_cycle", done, 1'b0);
        mism = 0;
        for (int a = 0; a < CELLS; a++)
            if ((mem[a] == 8'h01) != exp_board[a] || mem[a] > 8'h01) mism++;
        check("board_map", mism, 0);
        check("exp_q_drained", exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        #(10 * 95000);
        $display("FAIL global_timeout: got running expected finished");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "global timeout");
    end

    initial begin
        int c, stalls, mism;
        for (int a = 0; a < CELLS; a++) mem[a] = 8'($urandom);
        repeat (3) tick();
        check("rst_bus", {wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o}, 19'h0);
        check("rst_busy_done_err", {busy, done, err}, 3'b000);
        check("rst_mines", mines_placed, 8'h00);
        check("rst_state", dbg_state_o, 3'd0);
        rst_n = 1'b1;
        tick();

        // Reset while a clear access is on the bus.
        start = 1'b1;
        seed  = 16'h0001;
        tick();
        start = 1'b0;
        repeat (50) tick();
        c = 0;
        while (!wb_stb_o && c < 5) begin
            tick();
            c++;
        end
        check("stb_before_reset", wb_stb_o, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("async_cyc_stb_busy", {wb_cyc_o, wb_stb_o, busy}, 3'b000);
        check("async_rest", {wb_we_o, wb_adr_o, wb_dat_o, done, err, mines_placed}, 30'h0);
        tick();
        rst_n = 1'b1;
        tick();
        exp_q.delete();
        mon_en = 1'b1;

        run_game(16'h0001, 0, 1, 1'b0);
        run_game(16'h1234, 0, 1, 1'b1);
        run_game(16'h0000, 0, 1, 1'b0);
        for (int a = 0; a < CELLS; a++) snap_board[a] = (mem[a] == 8'h01);
        run_game(16'hACE1, 0, 1, 1'b0);
        mism = 0;
        for (int a = 0; a < CELLS; a++) if (snap_board[a] != (mem[a] == 8'h01)) mism++;
        check("seed0_equals_default", mism, 0);
        repeat (3) run_game(16'($urandom), 0, $urandom_range(0, 2), 1'b0);
        run_game(16'($urandom), CELLS - MINES, 1, 1'b0);
        mism = 0;
        for (int a = 0; a < CELLS; a++) if (mem[a] != 8'h01) mism++;
        check("collision_full_board", mism, 0);
        preset_n = 0;

`ifdef BOARD_PLACER_TIMEOUT_EN
        mon_en  = 1'b0;
        no_ack  = 1'b1;
        spur_en = 1'b0;
        start = 1'b1;
        seed  = 16'h0042;
        tick();
        start = 1'b0;
        c = 0;
        stalls = 0;
        while (wb_cyc_o && c < 1000) begin
            if (wb_stb_o) stalls++;
            tick();
            c++;
        end
        check("wdog_stall_cycles", stalls, 255);
        check("wdog_flags", {wb_cyc_o, err, done, busy}, 4'b0110);
        check("wdog_mines", mines_placed, 8'h00);
        no_ack = 1'b0;
`else
        stalls = 0;
        check("err_tied_low", {err, stalls[0]}, 2'b00);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
